// File: rtl/mem_stage.sv
// LC-3b MEM stage: latches EX results, runs the data-memory handshake (word, byte,
// indirect, TRAP vector) and registers results for WB. `MEM_FWD_EN adds forwarding outputs.
module mem_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid_in,
    input  logic [WIDTH-1:0] ex_alu_in,
    input  logic [WIDTH-1:0] ex_br_in,
    input  logic [WIDTH-1:0] ex_dest_data_in,
    input  logic [WIDTH-1:0] ex_instruction_in,
    input  logic [WIDTH-1:0] ex_pc_in,
    output logic             mem_stall_out,
    output logic [WIDTH-1:0] mem_address,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_read,
    output logic             mem_write,
    output logic [1:0]       mem_byte_enable,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_resp,
    output logic             wb_valid,
    output logic [WIDTH-1:0] wb_instruction,
    output logic [WIDTH-1:0] wb_pc,
    output logic [WIDTH-1:0] wb_alu,
    output logic [WIDTH-1:0] wb_br,
    output logic [WIDTH-1:0] wb_mdr
`ifdef MEM_FWD_EN
    ,
    output logic             fwd_valid,
    output logic [2:0]       fwd_reg,
    output logic [WIDTH-1:0] fwd_data
`endif
);

    localparam logic [3:0] OP_LDB  = 4'b0010;
    localparam logic [3:0] OP_LDW  = 4'b0110;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STB  = 4'b0011;
    localparam logic [3:0] OP_STW  = 4'b0111;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    typedef enum logic [1:0] {IDLE, ACC1, ACC2} state_t;

    function automatic logic is_mem(input logic [3:0] op);
        return (op == OP_LDB) || (op == OP_LDW) || (op == OP_LDI) || (op == OP_STB) ||
               (op == OP_STW) || (op == OP_STI) || (op == OP_TRAP);
    endfunction

    function automatic logic is_load(input logic [3:0] op);
        return (op == OP_LDB) || (op == OP_LDW) || (op == OP_LDI) || (op == OP_TRAP);
    endfunction

    state_t           state_q, state_d;
    logic             lat_valid_q, lat_valid_d;
    logic [WIDTH-1:0] lat_alu_q, lat_alu_d;
    logic [WIDTH-1:0] lat_br_q, lat_br_d;
    logic [WIDTH-1:0] lat_src_q, lat_src_d;
    logic [WIDTH-1:0] lat_ir_q, lat_ir_d;
    logic [WIDTH-1:0] lat_pc_q, lat_pc_d;
    logic [WIDTH-1:0] ind_q, ind_d;
    logic             wb_valid_q, wb_valid_d;
    logic [WIDTH-1:0] wb_ir_q, wb_ir_d;
    logic [WIDTH-1:0] wb_pc_q, wb_pc_d;
    logic [WIDTH-1:0] wb_alu_q, wb_alu_d;
    logic [WIDTH-1:0] wb_br_q, wb_br_d;
    logic [WIDTH-1:0] wb_mdr_q, wb_mdr_d;

    logic [3:0]       op;
    logic             indirect;
    logic             byte_op;
    logic             complete;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] load_data;

    assign op       = lat_ir_q[15:12];
    assign indirect = (op == OP_LDI) || (op == OP_STI);
    assign byte_op  = (op == OP_LDB) || (op == OP_STB);

    // An access finishes on the resp that ends its last phase; stall drops in that same cycle.
    always_comb begin
        complete = 1'b0;
        if (state_q == ACC1 && mem_resp && !indirect) complete = 1'b1;
        if (state_q == ACC2 && mem_resp)              complete = 1'b1;
    end

    assign mem_stall_out = lat_valid_q && is_mem(op) && (state_q != IDLE) && !complete;

    always_comb begin
        lat_valid_d = mem_stall_out ? lat_valid_q : ex_valid_in;
        lat_alu_d   = mem_stall_out ? lat_alu_q   : ex_alu_in;
        lat_br_d    = mem_stall_out ? lat_br_q    : ex_br_in;
        lat_src_d   = mem_stall_out ? lat_src_q   : ex_dest_data_in;
        lat_ir_d    = mem_stall_out ? lat_ir_q    : ex_instruction_in;
        lat_pc_d    = mem_stall_out ? lat_pc_q    : ex_pc_in;
    end

    always_comb begin
        state_d = state_q;
        ind_d   = ind_q;
        if (!mem_stall_out) begin
            state_d = (ex_valid_in && is_mem(ex_instruction_in[15:12])) ? ACC1 : IDLE;
        end else if (state_q == ACC1 && mem_resp) begin
            state_d = ACC2;
            ind_d   = mem_rdata;
        end
    end

    // The second phase of LDI/STI targets the pointer fetched in the first phase.
    always_comb begin
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 2'b00;
        req_addr        = (state_q == ACC2) ? ind_q : lat_alu_q;
        mem_address     = {req_addr[WIDTH-1:1], 1'b0};
        mem_wdata       = (op == OP_STB) ? {lat_src_q[7:0], lat_src_q[7:0]} : lat_src_q;
        if (lat_valid_q && state_q == ACC1) begin
            mem_write = (op == OP_STB) || (op == OP_STW);
            mem_read  = !mem_write;
        end else if (lat_valid_q && state_q == ACC2) begin
            mem_read  = (op == OP_LDI);
            mem_write = (op == OP_STI);
        end
        if (mem_read || mem_write) begin
            if (byte_op) begin
                mem_address     = req_addr;
                mem_byte_enable = req_addr[0] ? 2'b10 : 2'b01;
            end else begin
                mem_byte_enable = 2'b11;
            end
        end
    end

    always_comb begin
        load_data = mem_rdata;
        if (op == OP_LDB) begin
            load_data = lat_alu_q[0] ? {{(WIDTH-8){1'b0}}, mem_rdata[15:8]}
                                     : {{(WIDTH-8){1'b0}}, mem_rdata[7:0]};
        end
    end

    always_comb begin
        wb_valid_d = lat_valid_q && !mem_stall_out;
        wb_ir_d    = lat_ir_q;
        wb_pc_d    = lat_pc_q;
        wb_alu_d   = lat_alu_q;
        wb_br_d    = lat_br_q;
        wb_mdr_d   = (complete && is_load(op)) ? load_data : wb_mdr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            lat_valid_q <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_ir_q     <= '0;
            wb_pc_q     <= '0;
            wb_alu_q    <= '0;
            wb_br_q     <= '0;
            wb_mdr_q    <= '0;
        end else begin
            state_q     <= state_d;
            lat_valid_q <= lat_valid_d;
            wb_valid_q  <= wb_valid_d;
            wb_ir_q     <= wb_ir_d;
            wb_pc_q     <= wb_pc_d;
            wb_alu_q    <= wb_alu_d;
            wb_br_q     <= wb_br_d;
            wb_mdr_q    <= wb_mdr_d;
        end
    end

    // Latched operands are qualified by lat_valid_q, so they carry no reset.
    always_ff @(posedge clk) begin
        lat_alu_q <= lat_alu_d;
        lat_br_q  <= lat_br_d;
        lat_src_q <= lat_src_d;
        lat_ir_q  <= lat_ir_d;
        lat_pc_q  <= lat_pc_d;
        ind_q     <= ind_d;
    end

    assign wb_valid       = wb_valid_q;
    assign wb_instruction = wb_ir_q;
    assign wb_pc          = wb_pc_q;
    assign wb_alu         = wb_alu_q;
    assign wb_br          = wb_br_q;
    assign wb_mdr         = wb_mdr_q;

`ifdef MEM_FWD_EN
    logic [3:0] wb_op;
    logic       writes_reg;

    assign wb_op      = wb_ir_q[15:12];
    assign writes_reg = (wb_op == 4'b0001) || (wb_op == 4'b0101) || (wb_op == 4'b1001) ||
                        (wb_op == 4'b1101) || (wb_op == 4'b1110) || (wb_op == OP_LDB) ||
                        (wb_op == OP_LDW)  || (wb_op == OP_LDI)  || (wb_op == OP_TRAP);
    assign fwd_valid  = wb_valid_q && writes_reg;
    assign fwd_reg    = (wb_op == OP_TRAP) ? 3'd7 : wb_ir_q[11:9];
    assign fwd_data   = ((wb_op == OP_LDB) || (wb_op == OP_LDW) || (wb_op == OP_LDI)) ? wb_mdr_q
                                                                                      : wb_alu_q;
`endif

endmodule
